ps2_key_decoder: RTL and testbench

Consumes the stream of raw PS/2 scan-code bytes produced by the keyboard receiver and turns it into discrete key events for the processor. It handles E0/F0 prefixes, tracks Shift/Ctrl/Caps Lock state, and translates a printable subset to ASCII. Completed events are buffered in a small show-ahead FIFO that the CPU-side bus logic pops.

---
 rtl/ps2_pkg.sv | 77 +++++++
 rtl/ps2_event_fifo.sv | 65 ++++++
 rtl/ps2_key_decoder.sv | 149 ++++++++++++++
 tb/tb_ps2_key_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types, event layout, scan-code constants and the ASCII translation
// used by the PS/2 key decoder and its event FIFO.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } prefix_state_e;

    localparam int EVT_W     = 24;
    localparam int BRK_BIT   = 23;
    localparam int EXT_BIT   = 22;
    localparam int SHIFT_BIT = 21;
    localparam int CTRL_BIT  = 20;
    localparam int CAPS_BIT  = 19;
    localparam int CODE_LSB  = 8;
    localparam int ASCII_LSB = 0;

    localparam logic [7:0] CODE_E0     = 8'hE0;
    localparam logic [7:0] CODE_F0     = 8'hF0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CTRL   = 8'h14;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    // Keyboard housekeeping bytes (ack, BAT result, echo, resend, error, pause prefix).
    function automatic logic is_ignored(input logic [7:0] code);
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] scancode_to_ascii(input logic [7:0] code,
                                                     input logic shift,
                                                     input logic caps);
        logic [7:0] lc;
        logic [7:0] res;
        lc  = 8'h00;
        res = 8'h00;
        case (code)
            8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
            8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
            8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
            8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
            8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
            8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
            8'h35: lc = "y";  8'h1A: lc = "z";
            default: lc = 8'h00;
        endcase
        if (lc != 8'h00) begin
            res = (shift ^ caps) ? (lc - 8'h20) : lc;
        end else begin
            case (code)
                8'h16: res = shift ? "!" : "1";
                8'h1E: res = shift ? "@" : "2";
                8'h26: res = shift ? "#" : "3";
                8'h25: res = shift ? "$" : "4";
                8'h2E: res = shift ? "%" : "5";
                8'h36: res = shift ? "^" : "6";
                8'h3D: res = shift ? "&" : "7";
                8'h3E: res = shift ? "*" : "8";
                8'h46: res = shift ? "(" : "9";
                8'h45: res = shift ? ")" : "0";
                8'h29: res = 8'h20;
                8'h5A: res = 8'h0D;
                8'h66: res = 8'h08;
                8'h76: res = 8'h1B;
                default: res = 8'h00;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only when a pop
// frees a slot in the same cycle.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    // Empty FIFO presents zero rather than stale storage.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns raw PS/2 set-2 scan-code bytes into key events with modifier flags
// and ASCII, queued in a show-ahead FIFO for the CPU.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    input  logic                   rd_en,
    output logic [EVT_W-1:0]       evt_data,
    output logic                   evt_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   caps_led
);
    prefix_state_e state_q, state_d;
    logic          fire, brk, ext;
    logic          lshift_q, lshift_d, rshift_q, rshift_d;
    logic          ctrl_q, ctrl_d, caps_q, caps_d, caps_held_q, caps_held_d;
    logic          overflow_q, overflow_d;
    logic          shift;
    logic [EVT_W-1:0] evt_d;
    logic          fifo_full, fifo_empty, dropped, pop_ok;

    assign shift = lshift_q | rshift_q;

    // Prefix FSM: fire marks the byte that completes an event.
    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        brk     = 1'b0;
        ext     = 1'b0;
        if (byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_in == CODE_E0)      state_d = ST_GOT_E0;
                    else if (byte_in == CODE_F0) state_d = ST_GOT_F0;
                    else if (!is_ignored(byte_in)) fire = 1'b1;
                end
                ST_GOT_E0: begin
                    if (byte_in == CODE_F0) begin
                        state_d = ST_GOT_E0F0;
                    end else begin
                        fire    = 1'b1;
                        ext     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_GOT_F0: begin
                    fire    = 1'b1;
                    brk     = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_GOT_E0F0: begin
                    fire    = 1'b1;
                    brk     = 1'b1;
                    ext     = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Flags in the event reflect modifier state before this byte is applied.
    always_comb begin
        evt_d            = '0;
        evt_d[BRK_BIT]   = brk;
        evt_d[EXT_BIT]   = ext;
        evt_d[SHIFT_BIT] = shift;
        evt_d[CTRL_BIT]  = ctrl_q;
        evt_d[CAPS_BIT]  = caps_q;
        evt_d[CODE_LSB +: 8] = byte_in;
        if (!brk && !ext) evt_d[ASCII_LSB +: 8] = scancode_to_ascii(byte_in, shift, caps_q);
    end

    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        ctrl_d      = ctrl_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        if (fire) begin
            if (byte_in == CODE_LSHIFT && !ext) lshift_d = !brk;
            if (byte_in == CODE_RSHIFT && !ext) rshift_d = !brk;
            if (byte_in == CODE_CTRL)           ctrl_d   = !brk;
            if (byte_in == CODE_CAPS && !ext) begin
                if (brk) begin
                    caps_held_d = 1'b0;
                end else if (!caps_held_q) begin
                    caps_d      = !caps_q;
                    caps_held_d = 1'b1;
                end
            end
        end
    end

    assign pop_ok  = rd_en && !fifo_empty;
    assign dropped = fire && fifo_full && !rd_en;

    always_comb begin
        overflow_d = overflow_q;
        if (pop_ok)       overflow_d = 1'b0;
        else if (dropped) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            ctrl_q      <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            ctrl_q      <= ctrl_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            overflow_q  <= overflow_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(EVT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fire),
        .wdata_i (evt_d),
        .pop_i   (rd_en),
        .rdata_o (evt_data),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign overflow  = overflow_q;
    assign caps_led  = caps_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: each task drives one scenario and checks
// hand-computed event words inline.
module tb_ps2_key_decoder;
    logic        clk;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        rd_en;
    logic [23:0] evt_data;
    logic        evt_valid;
    logic [3:0]  count;
    logic        overflow;
    logic        caps_led;

    int checks;
    int errors;

    ps2_key_decoder #(.DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .rd_en      (rd_en),
        .evt_data   (evt_data),
        .evt_valid  (evt_valid),
        .count      (count),
        .overflow   (overflow),
        .caps_led   (caps_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the next negedge with the strobe consumed.
    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid got %b exp 0", evt_valid); end
        checks++; if (evt_data !== 24'h0) begin errors++; $display("FAIL reset_evt_data got %h exp 000000", evt_data); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (caps_led !== 1'b0) begin errors++; $display("FAIL reset_caps got %b exp 0", caps_led); end
    endtask

    task automatic test_single();
        send(8'h1C);
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", evt_valid); end
        checks++; if (evt_data !== 24'h001C61) begin errors++; $display("FAIL single_data got %h exp 001c61", evt_data); end
        pop();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %b exp 0", evt_valid); end
    endtask

    task automatic test_shift();
        logic [7:0]  seq [6];
        logic [23:0] exp [4];
        seq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
        exp = '{24'h001200, 24'h201C41, 24'hA01C00, 24'hA01200};
        for (int i = 0; i < 6; i++) send(seq[i]);
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL shift_count got %0d exp 4", count); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_data !== exp[i]) begin
                errors++; $display("FAIL shift_evt%0d got %b/%h exp 1/%h", i, evt_valid, evt_data, exp[i]);
            end
            pop();
        end
    endtask

    task automatic test_prefix();
        send(8'hE0); send(8'hF0); send(8'h75);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL e0f0_count got %0d exp 1", count); end
        checks++; if (evt_data !== 24'hC07500) begin errors++; $display("FAIL e0f0_data got %h exp c07500", evt_data); end
        pop();
        send(8'hAA); send(8'hFA); send(8'hE0);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL ignored_count got %0d exp 0", count); end
        // The lone E0 left a pending prefix, so 75 must come out extended.
        send(8'h75);
        checks++; if (evt_data !== 24'h407500) begin errors++; $display("FAIL e0_ext_data got %h exp 407500", evt_data); end
        pop();
    endtask

    task automatic test_caps();
        logic [23:0] exp [5];
        exp = '{24'h005800, 24'h085800, 24'h085800, 24'h885800, 24'h081C41};
        send(8'h58);
        checks++; if (caps_led !== 1'b1) begin errors++; $display("FAIL caps_first got %b exp 1", caps_led); end
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
        checks++; if (caps_led !== 1'b1) begin errors++; $display("FAIL caps_hold got %b exp 1", caps_led); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_data !== exp[i]) begin
                errors++; $display("FAIL caps_evt%0d got %b/%h exp 1/%h", i, evt_valid, evt_data, exp[i]);
            end
            pop();
        end
    endtask

    // Caps Lock is on from the previous test.
    task automatic test_ascii();
        logic [7:0]  seq [10];
        logic [23:0] exp [7];
        seq = '{8'h16, 8'h29, 8'h12, 8'h16, 8'h1C, 8'hF0, 8'h12, 8'hE0, 8'h1C, 8'h5A};
        exp = '{24'h081631, 24'h082920, 24'h081200, 24'h281621, 24'h281C61, 24'hA81200, 24'h481C00};
        for (int i = 0; i < 9; i++) send(seq[i]);
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL ascii_count got %0d exp 7", count); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (evt_data !== exp[i]) begin
                errors++; $display("FAIL ascii_evt%0d got %h exp %h", i, evt_data, exp[i]);
            end
            pop();
        end
        send(seq[9]);
        checks++; if (evt_data !== 24'h085A0D) begin errors++; $display("FAIL ascii_enter got %h exp 085a0d", evt_data); end
        pop();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) send(8'h1C);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        byte_in    = 8'h1C;
        byte_valid = 1'b1;
        rd_en      = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        rd_en      = 1'b0;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_pushpop_count got %0d exp 8", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (evt_data !== 24'h081C41) begin
                errors++; $display("FAIL ovf_drain%0d got %h exp 081c41", i, evt_data);
            end
            pop();
        end
        checks++; if (count !== 4'd0 || evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0d/%b exp 0/0", count, evt_valid); end
    endtask

    task automatic test_reset_mid_prefix();
        send(8'hE0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (caps_led !== 1'b0) begin errors++; $display("FAIL rst_mid_caps got %b exp 0", caps_led); end
        send(8'h75);
        checks++; if (evt_valid !== 1'b1 || evt_data !== 24'h007500) begin
            errors++; $display("FAIL rst_mid_data got %b/%h exp 1/007500", evt_valid, evt_data);
        end
        pop();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        rd_en      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_shift();
        test_prefix();
        test_caps();
        test_ascii();
        test_overflow();
        test_reset_mid_prefix();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
